// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage_if
//  Brief    : Bundles the upstream op, retire and data-cache request signals
//             of the memory pipeline stage. The slave modport is the stage's
//             view; the master modport is the surrounding pipeline and cache.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_stage_if #(
   parameter int XLEN       = 64,
   parameter int ADDR_W     = 64,
   parameter int LINE_BYTES = 64,
   parameter int SB_W       = 16
);
   localparam int c_NB        = XLEN / 8;
   localparam int c_OFF_W     = $clog2(c_NB);
   localparam int c_LINE_W    = $clog2(LINE_BYTES);
   localparam int c_WSEL_BITS = c_LINE_W - c_OFF_W;
   localparam int c_WSEL_W    = (c_WSEL_BITS > 0) ? c_WSEL_BITS : 1;
   localparam int c_LA_W      = ADDR_W - c_LINE_W;

   // upstream op
   logic                in_valid;
   logic                in_ready;
   logic                in_is_load;
   logic                in_is_store;
   logic [1:0]          in_size;
   logic                in_signed;
   logic [ADDR_W-1:0]   in_addr;
   logic [XLEN-1:0]     in_wdata;
   logic [SB_W-1:0]     in_sb;
   // retire
   logic                out_valid;
   logic [XLEN-1:0]     out_result;
   logic [SB_W-1:0]     out_sb;
   logic [1:0]          out_exc;
   // data cache
   logic                dc_req;
   logic                dc_we;
   logic [c_LA_W-1:0]   dc_line_addr;
   logic [c_WSEL_W-1:0] dc_word_sel;
   logic [c_NB-1:0]     dc_byte_en;
   logic [XLEN-1:0]     dc_wdata;
   logic                dc_ack;
   logic [XLEN-1:0]     dc_rdata;

   modport slave (
      input  in_valid, in_is_load, in_is_store, in_size, in_signed,
             in_addr, in_wdata, in_sb, dc_ack, dc_rdata,
      output in_ready, out_valid, out_result, out_sb, out_exc,
             dc_req, dc_we, dc_line_addr, dc_word_sel, dc_byte_en, dc_wdata
   );

   modport master (
      output in_valid, in_is_load, in_is_store, in_size, in_signed,
             in_addr, in_wdata, in_sb, dc_ack, dc_rdata,
      input  in_ready, out_valid, out_result, out_sb, out_exc,
             dc_req, dc_we, dc_line_addr, dc_word_sel, dc_byte_en, dc_wdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage
//  Brief    : Memory pipeline stage. Passes non-memory ops through in one
//             cycle, flags misaligned accesses, issues big-endian data-cache
//             requests with byte enables and replicated store data, aligns
//             and extends load data, and bounds the ack wait with a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_stage #(
   parameter int XLEN       = 64,
   parameter int ADDR_W     = 64,
   parameter int LINE_BYTES = 64,
   parameter int SB_W       = 16,
   parameter int TIMEOUT    = 256
) (
   input  logic                clk,
   input  logic                reset,
   lsu_mem_stage_if.slave      bus
);
   localparam int c_NB        = XLEN / 8;
   localparam int c_OFF_W     = $clog2(c_NB);
   localparam int c_LINE_W    = $clog2(LINE_BYTES);
   localparam int c_WSEL_BITS = c_LINE_W - c_OFF_W;
   localparam int c_WSEL_W    = (c_WSEL_BITS > 0) ? c_WSEL_BITS : 1;
   localparam int c_LA_W      = ADDR_W - c_LINE_W;
   localparam int c_CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [0:0] c_S_IDLE = 1'b0;
   localparam logic [0:0] c_S_WAIT = 1'b1;

   localparam logic [1:0] c_EXC_NONE  = 2'd0;
   localparam logic [1:0] c_EXC_ALIGN = 2'd1;
   localparam logic [1:0] c_EXC_BUS   = 2'd2;

   // state and captured op
   logic [0:0]          state_q, state_d;
   logic [c_CNT_W-1:0]  cnt_q, cnt_d;
   logic                op_load_q, op_load_d;
   logic                op_signed_q, op_signed_d;
   logic [1:0]          op_size_q, op_size_d;
   logic [c_OFF_W-1:0]  op_off_q, op_off_d;
   logic [SB_W-1:0]     op_sb_q, op_sb_d;
   // cache request
   logic                dc_req_q, dc_req_d;
   logic                dc_we_q, dc_we_d;
   logic [c_LA_W-1:0]   dc_line_q, dc_line_d;
   logic [c_WSEL_W-1:0] dc_wsel_q, dc_wsel_d;
   logic [c_NB-1:0]     dc_be_q, dc_be_d;
   logic [XLEN-1:0]     dc_wdata_q, dc_wdata_d;
   // retire
   logic                out_valid_q, out_valid_d;
   logic [XLEN-1:0]     out_result_q, out_result_d;
   logic [SB_W-1:0]     out_sb_q, out_sb_d;
   logic [1:0]          out_exc_q, out_exc_d;

   logic                w_accept;
   logic                w_is_mem;
   logic                w_misalign;
   logic [2:0]          w_low_bits;
   logic [c_WSEL_W-1:0] w_wsel;
   logic [c_NB-1:0]     w_be;
   logic [XLEN-1:0]     w_wrep;
   logic [XLEN-1:0]     w_load_res;

   assign w_accept = bus.in_valid && (state_q == c_S_IDLE);
   assign w_is_mem = bus.in_is_load || bus.in_is_store;

   generate
      if (c_WSEL_BITS > 0) begin : g_wsel
         assign w_wsel = bus.in_addr[c_LINE_W-1:c_OFF_W];
      end else begin : g_wsel_none
         assign w_wsel = '0;
      end
   endgenerate

   // Misalignment: low address bits inside the access, access wider than the word, or load+store together
   always_comb begin
      w_low_bits = bus.in_addr[2:0] & ((3'd1 << bus.in_size) - 3'd1);
      w_misalign = (w_low_bits != 3'd0)
                || ((32'd1 << bus.in_size) > 32'(c_NB))
                || (bus.in_is_load && bus.in_is_store);
   end

   // Byte enables and store-data replication for the incoming op (big-endian lanes)
   always_comb begin
      int off;
      int nbytes;
      off    = int'(bus.in_addr[c_OFF_W-1:0]);
      nbytes = 1 << bus.in_size;
      w_be   = '0;
      w_wrep = '0;
      for (int i = 0; i < c_NB; i++) begin
         w_be[c_NB-1-i] = (i >= off) && (i < off + nbytes);
      end
      // byte b counts from the least-significant end; repeat the right-justified chunk
      for (int b = 0; b < c_NB; b++) begin
         case (bus.in_size)
            2'd0:    w_wrep[b*8 +: 8] = bus.in_wdata[7:0];
            2'd1:    w_wrep[b*8 +: 8] = bus.in_wdata[(b % 2)*8 +: 8];
            2'd2:    w_wrep[b*8 +: 8] = bus.in_wdata[(b % 4)*8 +: 8];
            default: w_wrep[b*8 +: 8] = bus.in_wdata[(b % 8)*8 +: 8];
         endcase
      end
   end

   // Load alignment: shift the selected lanes down to bit 0, then sign- or zero-extend
   always_comb begin
      int nbytes;
      int nbits;
      int sh;
      int top;
      logic [XLEN-1:0] shifted;
      logic [XLEN-1:0] mask;
      logic            sgn;
      nbytes  = 1 << op_size_q;
      nbits   = nbytes * 8;
      sh      = (c_NB - int'(op_off_q) - nbytes) * 8;
      if (sh < 0) sh = 0;
      shifted = bus.dc_rdata >> sh;
      top     = ((nbits > XLEN) ? XLEN : nbits) - 1;
      mask    = '0;
      for (int i = 0; i < XLEN; i++) begin
         mask[i] = (i < nbits);
      end
      sgn        = op_signed_q && shifted[top];
      w_load_res = (shifted & mask) | ({XLEN{sgn}} & ~mask);
   end

   // Next-state: accept in IDLE, retire on ack or watchdog expiry in WAIT
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_load_d    = op_load_q;
      op_signed_d  = op_signed_q;
      op_size_d    = op_size_q;
      op_off_d     = op_off_q;
      op_sb_d      = op_sb_q;
      dc_req_d     = dc_req_q;
      dc_we_d      = dc_we_q;
      dc_line_d    = dc_line_q;
      dc_wsel_d    = dc_wsel_q;
      dc_be_d      = dc_be_q;
      dc_wdata_d   = dc_wdata_q;
      out_valid_d  = 1'b0;
      out_result_d = out_result_q;
      out_sb_d     = out_sb_q;
      out_exc_d    = out_exc_q;

      case (state_q)
         c_S_IDLE: begin
            if (w_accept) begin
               op_load_d   = bus.in_is_load;
               op_signed_d = bus.in_signed;
               op_size_d   = bus.in_size;
               op_off_d    = bus.in_addr[c_OFF_W-1:0];
               op_sb_d     = bus.in_sb;
               if (!w_is_mem) begin
                  out_valid_d  = 1'b1;
                  out_result_d = bus.in_addr[XLEN-1:0];
                  out_sb_d     = bus.in_sb;
                  out_exc_d    = c_EXC_NONE;
               end else if (w_misalign) begin
                  out_valid_d  = 1'b1;
                  out_result_d = '0;
                  out_sb_d     = bus.in_sb;
                  out_exc_d    = c_EXC_ALIGN;
               end else begin
                  state_d    = c_S_WAIT;
                  cnt_d      = '0;
                  dc_req_d   = 1'b1;
                  dc_we_d    = bus.in_is_store;
                  dc_line_d  = bus.in_addr[ADDR_W-1:c_LINE_W];
                  dc_wsel_d  = w_wsel;
                  dc_be_d    = w_be;
                  dc_wdata_d = w_wrep;
               end
            end
         end
         c_S_WAIT: begin
            if (bus.dc_ack) begin
               // ack beats a watchdog expiry landing on the same edge
               state_d      = c_S_IDLE;
               dc_req_d     = 1'b0;
               out_valid_d  = 1'b1;
               out_result_d = op_load_q ? w_load_res : '0;
               out_sb_d     = op_sb_q;
               out_exc_d    = c_EXC_NONE;
            end else if ((TIMEOUT != 0) && (cnt_q == c_CNT_LAST)) begin
               state_d      = c_S_IDLE;
               dc_req_d     = 1'b0;
               out_valid_d  = 1'b1;
               out_result_d = '0;
               out_sb_d     = op_sb_q;
               out_exc_d    = c_EXC_BUS;
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end
         default: begin
            state_d  = c_S_IDLE;
            dc_req_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any outstanding request
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= c_S_IDLE;
         cnt_q        <= '0;
         op_load_q    <= 1'b0;
         op_signed_q  <= 1'b0;
         op_size_q    <= 2'd0;
         op_off_q     <= '0;
         op_sb_q      <= '0;
         dc_req_q     <= 1'b0;
         dc_we_q      <= 1'b0;
         dc_line_q    <= '0;
         dc_wsel_q    <= '0;
         dc_be_q      <= '0;
         dc_wdata_q   <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_sb_q     <= '0;
         out_exc_q    <= 2'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_load_q    <= op_load_d;
         op_signed_q  <= op_signed_d;
         op_size_q    <= op_size_d;
         op_off_q     <= op_off_d;
         op_sb_q      <= op_sb_d;
         dc_req_q     <= dc_req_d;
         dc_we_q      <= dc_we_d;
         dc_line_q    <= dc_line_d;
         dc_wsel_q    <= dc_wsel_d;
         dc_be_q      <= dc_be_d;
         dc_wdata_q   <= dc_wdata_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_sb_q     <= out_sb_d;
         out_exc_q    <= out_exc_d;
      end
   end

   assign bus.in_ready     = (state_q == c_S_IDLE);
   assign bus.out_valid    = out_valid_q;
   assign bus.out_result   = out_result_q;
   assign bus.out_sb       = out_sb_q;
   assign bus.out_exc      = out_exc_q;
   assign bus.dc_req       = dc_req_q;
   assign bus.dc_we        = dc_we_q;
   assign bus.dc_line_addr = dc_line_q;
   assign bus.dc_word_sel  = dc_wsel_q;
   assign bus.dc_byte_en   = dc_be_q;
   assign bus.dc_wdata     = dc_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_stage
//  Brief    : Directed bench for lsu_mem_stage (XLEN=64, TIMEOUT=4) with a
//             scoreboard of expected retirements.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_stage;
   localparam int XLEN       = 64;
   localparam int ADDR_W     = 64;
   localparam int LINE_BYTES = 64;
   localparam int SB_W       = 16;
   localparam int TIMEOUT    = 4;

   typedef struct {
      logic [XLEN-1:0] res;
      logic            chk_res;
      logic [SB_W-1:0] sb;
      logic [1:0]      exc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   lsu_mem_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SB_W(SB_W)) bus ();

   lsu_mem_stage #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SB_W(SB_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input logic [63:0] res, input logic cr, input logic [15:0] sb, input logic [1:0] exc);
      exp_t e;
      e.res = res; e.chk_res = cr; e.sb = sb; e.exc = exc;
      sbq.push_back(e);
   endtask

   // caller sits at a negedge; returns at the negedge after the accepting posedge
   task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd, input logic [15:0] sb);
      bus.in_valid    = 1'b1;
      bus.in_is_load  = ld;
      bus.in_is_store = st;
      bus.in_size     = sz;
      bus.in_signed   = sg;
      bus.in_addr     = a;
      bus.in_wdata    = wd;
      bus.in_sb       = sb;
      @(negedge clk);
      bus.in_valid    = 1'b0;
   endtask

   // retirement monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && bus.out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
         end else begin
            e = sbq.pop_front();
            if (e.chk_res) chk("out_result", bus.out_result, e.res);
            chk("out_sb", 64'(bus.out_sb), 64'(e.sb));
            chk("out_exc", 64'(bus.out_exc), 64'(e.exc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      int n;
      reset           = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_is_load  = 1'b0;
      bus.in_is_store = 1'b0;
      bus.in_size     = 2'd0;
      bus.in_signed   = 1'b0;
      bus.in_addr     = '0;
      bus.in_wdata    = '0;
      bus.in_sb       = '0;
      bus.dc_ack      = 1'b0;
      bus.dc_rdata    = 64'h0011_2233_8899_AABB;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_in_ready",   64'(bus.in_ready), 64'd1);
      chk("rst_out_valid",  64'(bus.out_valid), 64'd0);
      chk("rst_out_result", bus.out_result, 64'd0);
      chk("rst_out_sb",     64'(bus.out_sb), 64'd0);
      chk("rst_out_exc",    64'(bus.out_exc), 64'd0);
      chk("rst_dc_req",     64'(bus.dc_req), 64'd0);
      chk("rst_dc_we",      64'(bus.dc_we), 64'd0);
      chk("rst_dc_line",    64'(bus.dc_line_addr), 64'd0);
      chk("rst_dc_wsel",    64'(bus.dc_word_sel), 64'd0);
      chk("rst_dc_be",      64'(bus.dc_byte_en), 64'd0);
      chk("rst_dc_wdata",   bus.dc_wdata, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // non-memory pass-through
      expect_out(64'h1234, 1'b1, 16'h0A01, 2'd0);
      drive(1'b0, 1'b0, 2'd3, 1'b0, 64'h1234, 64'h0, 16'h0A01);
      chk("nm_out_valid", 64'(bus.out_valid), 64'd1);
      chk("nm_dc_req",    64'(bus.dc_req), 64'd0);
      chk("nm_in_ready",  64'(bus.in_ready), 64'd1);

      // signed byte load, ack in the 4th WAIT cycle (same edge the watchdog would fire: ack wins)
      expect_out(64'hFFFF_FFFF_FFFF_FF88, 1'b1, 16'h0B02, 2'd0);
      drive(1'b1, 1'b0, 2'd0, 1'b1, 64'h1004, 64'h0, 16'h0B02);
      chk("sb_dc_req",   64'(bus.dc_req), 64'd1);
      chk("sb_dc_we",    64'(bus.dc_we), 64'd0);
      chk("sb_dc_be",    64'(bus.dc_byte_en), 64'h08);
      chk("sb_dc_line",  64'(bus.dc_line_addr), 64'h40);
      chk("sb_dc_wsel",  64'(bus.dc_word_sel), 64'd0);
      chk("sb_in_ready", 64'(bus.in_ready), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("sb_req_held", 64'(bus.dc_req), 64'd1);
      end
      bus.dc_ack = 1'b1;
      @(negedge clk);
      bus.dc_ack = 1'b0;
      chk("sb_req_drop",  64'(bus.dc_req), 64'd0);
      chk("sb_out_valid", 64'(bus.out_valid), 64'd1);

      // unsigned half load with single-cycle ack
      expect_out(64'h0000_0000_0000_AABB, 1'b1, 16'h0C03, 2'd0);
      drive(1'b1, 1'b0, 2'd1, 1'b0, 64'h1006, 64'h0, 16'h0C03);
      chk("uh_dc_be", 64'(bus.dc_byte_en), 64'h03);
      bus.dc_ack = 1'b1;
      @(negedge clk);
      bus.dc_ack = 1'b0;
      chk("uh_in_ready", 64'(bus.in_ready), 64'd1);

      // half store accepted on the cycle right after the previous ack
      expect_out(64'h0, 1'b1, 16'h0D04, 2'd0);
      drive(1'b0, 1'b1, 2'd1, 1'b0, 64'h2002, 64'hBEEF, 16'h0D04);
      chk("hs_dc_req",   64'(bus.dc_req), 64'd1);
      chk("hs_dc_we",    64'(bus.dc_we), 64'd1);
      chk("hs_dc_wsel",  64'(bus.dc_word_sel), 64'd0);
      chk("hs_dc_line",  64'(bus.dc_line_addr), 64'h80);
      chk("hs_dc_be",    64'(bus.dc_byte_en), 64'h30);
      chk("hs_dc_wdata", bus.dc_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
      @(negedge clk);
      chk("hs_wdata_stable", bus.dc_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
      bus.dc_ack = 1'b1;
      @(negedge clk);
      bus.dc_ack = 1'b0;

      // misaligned word load
      expect_out(64'h0, 1'b0, 16'h0E05, 2'd1);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'h0, 16'h0E05);
      chk("ma_dc_req",    64'(bus.dc_req), 64'd0);
      chk("ma_in_ready",  64'(bus.in_ready), 64'd1);
      chk("ma_out_valid", 64'(bus.out_valid), 64'd1);

      // load and store together count as misaligned
      expect_out(64'h0, 1'b0, 16'h0F06, 2'd1);
      drive(1'b1, 1'b1, 2'd0, 1'b0, 64'h10, 64'h0, 16'h0F06);
      chk("ls_dc_req", 64'(bus.dc_req), 64'd0);

      // dc_ack while idle is ignored
      bus.dc_ack = 1'b1;
      @(negedge clk);
      bus.dc_ack = 1'b0;
      chk("idle_ack_out_valid", 64'(bus.out_valid), 64'd0);
      chk("idle_ack_in_ready",  64'(bus.in_ready), 64'd1);

      // watchdog: dword load never acked
      expect_out(64'h0, 1'b0, 16'h1107, 2'd2);
      drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h4008, 64'h0, 16'h1107);
      chk("to_dc_be", 64'(bus.dc_byte_en), 64'hFF);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.dc_req !== 1'b1) break;
         n++;
         @(negedge clk);
      end
      chk("to_req_cycles", 64'(n), 64'd4);
      chk("to_out_valid",  64'(bus.out_valid), 64'd1);

      // reset during the second WAIT cycle abandons the transaction
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h5000, 64'h0, 16'h1208);
      chk("rw_dc_req_before", 64'(bus.dc_req), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rw_dc_req",    64'(bus.dc_req), 64'd0);
      chk("rw_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rw_in_ready",  64'(bus.in_ready), 64'd1);
      chk("rw_out_sb",    64'(bus.out_sb), 64'd0);
      reset = 1'b0;
      bus.dc_ack = 1'b1;
      @(negedge clk);
      bus.dc_ack = 1'b0;
      chk("rw_late_ack_valid", 64'(bus.out_valid), 64'd0);
      chk("rw_late_ack_req",   64'(bus.dc_req), 64'd0);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
